// File: rtl/data_burst_controller.sv
// Moves data between the 256x8 register-bank array and the external burst interface, in bursts of at most max_burst_size beats.
// Define DB_TIMEOUT_EN to add a per-handshake watchdog that aborts a stalled transfer and sets db_err.
module data_burst_controller #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rb_db_start,
  input  logic       rb_db_rw,
  input  logic [7:0] rb_db_length,
  input  logic [7:0] rb_db_max_burst_size,
  input  logic [7:0] rb_db_data,
  input  logic       rb_db_ack,
  output logic       db_rb_req,
  output logic [8:0] db_rb_addr,
  output logic [7:0] db_rb_data,
  output logic       db_rb_idle,
  output logic       db_rb_rd_done,
  output logic       db_bi_req,
  output logic       db_bi_rw,
  output logic [8:0] db_bi_addr,
  output logic [7:0] db_bi_size,
  input  logic       bi_db_gnt,
  output logic [7:0] db_bi_wdata,
  output logic       db_bi_wvalid,
  input  logic       bi_db_wready,
  input  logic [7:0] bi_db_rdata,
  input  logic       bi_db_rvalid,
  output logic       db_err
);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_REQ, S_WBEAT, S_RBEAT, S_BEND, S_DONE
  } state_e;

  state_e     state_q, state_d;
  logic       rw_q, rw_d;
  logic [7:0] mbs_q, mbs_d;
  logic [7:0] remaining_q, remaining_d;
  logic [7:0] beat_cnt_q, beat_cnt_d;
  logic [8:0] ptr_q, ptr_d;
  logic       err_q, err_d;

  logic [7:0] burst_size;
  logic       beat_done;
  logic       handshake;
  logic       timeout_hit;

  // The acknowledge only mirrors our own strobe; nothing here depends on it.
  logic unused_ack;
  assign unused_ack = rb_db_ack;

  assign burst_size = (remaining_q < mbs_q) ? remaining_q : mbs_q;
  assign beat_done  = ((state_q == S_WBEAT) && bi_db_wready) ||
                      ((state_q == S_RBEAT) && bi_db_rvalid);
  assign handshake  = beat_done || ((state_q == S_REQ) && bi_db_gnt);

`ifdef DB_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);

  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            waiting;

  assign waiting     = (state_q == S_REQ) || (state_q == S_WBEAT) || (state_q == S_RBEAT);
  assign timeout_hit = waiting && !handshake && (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

  // Restart the count on every state change and every accepted handshake.
  always_comb begin
    to_cnt_d = to_cnt_q + TO_W'(1);
    if ((state_d != state_q) || handshake) to_cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) to_cnt_q <= '0;
    else        to_cnt_q <= to_cnt_d;
  end
`else
  logic [31:0] unused_timeout;
  assign unused_timeout = 32'(TIMEOUT_CYCLES);
  assign timeout_hit    = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      rw_q        <= 1'b0;
      mbs_q       <= 8'd0;
      remaining_q <= 8'd0;
      beat_cnt_q  <= 8'd0;
      ptr_q       <= 9'd0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      rw_q        <= rw_d;
      mbs_q       <= mbs_d;
      remaining_q <= remaining_d;
      beat_cnt_q  <= beat_cnt_d;
      ptr_q       <= ptr_d;
      err_q       <= err_d;
    end
  end

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (rb_db_start) state_d = S_SETUP;
      S_SETUP: state_d = (rb_db_length == 8'd0) ? S_DONE : S_REQ;
      S_REQ:   if (bi_db_gnt) state_d = rw_q ? S_WBEAT : S_RBEAT;
      S_WBEAT,
      S_RBEAT: if (beat_done && (beat_cnt_q == 8'd1)) state_d = S_BEND;
      S_BEND:  state_d = (remaining_q != 8'd0) ? S_REQ : S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (timeout_hit) state_d = S_DONE;
  end

  always_comb begin
    rw_d        = rw_q;
    mbs_d       = mbs_q;
    remaining_d = remaining_q;
    beat_cnt_d  = beat_cnt_q;
    ptr_d       = ptr_q;
    err_d       = err_q;
    case (state_q)
      S_SETUP: begin
        rw_d        = rb_db_rw;
        mbs_d       = (rb_db_max_burst_size == 8'd0) ? 8'd1 : rb_db_max_burst_size;
        remaining_d = rb_db_length;
        ptr_d       = 9'd0;
        err_d       = 1'b0;
      end
      S_REQ:   if (bi_db_gnt) beat_cnt_d = burst_size;
      default: ;
    endcase
    if (beat_done) begin
      ptr_d       = ptr_q + 9'd1;
      remaining_d = remaining_q - 8'd1;
      beat_cnt_d  = beat_cnt_q - 8'd1;
    end
    if (timeout_hit) err_d = 1'b1;
  end

  always_comb begin
    db_rb_req     = 1'b0;
    db_rb_addr    = 9'd0;
    db_rb_data    = 8'd0;
    db_rb_idle    = 1'b0;
    db_rb_rd_done = 1'b0;
    db_bi_req     = 1'b0;
    db_bi_addr    = 9'd0;
    db_bi_size    = 8'd0;
    db_bi_wdata   = 8'd0;
    db_bi_wvalid  = 1'b0;
    case (state_q)
      S_IDLE: db_rb_idle = 1'b1;
      S_REQ: begin
        db_bi_req  = 1'b1;
        db_bi_addr = ptr_q;
        db_bi_size = burst_size;
      end
      S_WBEAT: begin
        db_rb_req    = 1'b1;
        db_rb_addr   = ptr_q;
        db_bi_wdata  = rb_db_data;
        db_bi_wvalid = 1'b1;
      end
      S_RBEAT: begin
        if (bi_db_rvalid) begin
          db_rb_req  = 1'b1;
          db_rb_addr = ptr_q;
          db_rb_data = bi_db_rdata;
        end
      end
      // An aborted transfer leaves err_q set, which suppresses the completion pulse.
      S_DONE:  db_rb_rd_done = !rw_q && !err_q;
      default: ;
    endcase
  end

  assign db_bi_rw = rw_q;
  assign db_err   = err_q;

endmodule

// File: tb/tb_data_burst_controller.sv
// Directed self-checking bench for data_burst_controller; the watchdog test runs when DB_TIMEOUT_EN is defined.
`timescale 1ns/1ps
module tb_data_burst_controller;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rb_db_start;
  logic       rb_db_rw;
  logic [7:0] rb_db_length;
  logic [7:0] rb_db_max_burst_size;
  logic [7:0] rb_db_data;
  logic       rb_db_ack;
  logic       db_rb_req;
  logic [8:0] db_rb_addr;
  logic [7:0] db_rb_data;
  logic       db_rb_idle;
  logic       db_rb_rd_done;
  logic       db_bi_req;
  logic       db_bi_rw;
  logic [8:0] db_bi_addr;
  logic [7:0] db_bi_size;
  logic       bi_db_gnt;
  logic [7:0] db_bi_wdata;
  logic       db_bi_wvalid;
  logic       bi_db_wready;
  logic [7:0] bi_db_rdata;
  logic       bi_db_rvalid;
  logic       db_err;

  always #5 clk = ~clk;

  data_burst_controller #(.TIMEOUT_CYCLES(8)) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .rb_db_start          (rb_db_start),
    .rb_db_rw             (rb_db_rw),
    .rb_db_length         (rb_db_length),
    .rb_db_max_burst_size (rb_db_max_burst_size),
    .rb_db_data           (rb_db_data),
    .rb_db_ack            (rb_db_ack),
    .db_rb_req            (db_rb_req),
    .db_rb_addr           (db_rb_addr),
    .db_rb_data           (db_rb_data),
    .db_rb_idle           (db_rb_idle),
    .db_rb_rd_done        (db_rb_rd_done),
    .db_bi_req            (db_bi_req),
    .db_bi_rw             (db_bi_rw),
    .db_bi_addr           (db_bi_addr),
    .db_bi_size           (db_bi_size),
    .bi_db_gnt            (bi_db_gnt),
    .db_bi_wdata          (db_bi_wdata),
    .db_bi_wvalid         (db_bi_wvalid),
    .bi_db_wready         (bi_db_wready),
    .bi_db_rdata          (bi_db_rdata),
    .bi_db_rvalid         (bi_db_rvalid),
    .db_err               (db_err)
  );

  // Register-bank model: combinational read, written by read-direction beats.
  logic [7:0] bank [256];
  logic [7:0] rmem [256];
  assign rb_db_data = bank[db_rb_addr[7:0]];
  assign rb_db_ack  = db_rb_req;

  logic [8:0] burst_addr_q [$];
  logic [7:0] burst_size_q [$];
  logic [8:0] wb_addr_q [$];
  logic [7:0] wb_data_q [$];
  int         rd_done_cnt;
  int         bi_req_cycles;

  int checks = 0;
  int errors = 0;
  int n_cyc;

  logic [8:0] t1_addr [3] = '{9'd0, 9'd4, 9'd8};
  logic [7:0] t1_size [3] = '{8'd4, 8'd4, 8'd2};

  // Handshakes are sampled mid-cycle, where inputs and outputs are both stable.
  always @(negedge clk) begin
    if (rst_n) begin
      if (db_bi_req && bi_db_gnt) begin
        burst_addr_q.push_back(db_bi_addr);
        burst_size_q.push_back(db_bi_size);
      end
      if (db_bi_wvalid && bi_db_wready) begin
        wb_addr_q.push_back(db_rb_addr);
        wb_data_q.push_back(db_bi_wdata);
      end
      if (db_rb_req && !db_bi_rw) rmem[db_rb_addr[7:0]] = db_rb_data;
      if (db_rb_rd_done) rd_done_cnt++;
      if (db_bi_req) bi_req_cycles++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic start_xfer(input logic rw, input logic [7:0] len, input logic [7:0] mbs);
    burst_addr_q.delete();
    burst_size_q.delete();
    wb_addr_q.delete();
    wb_data_q.delete();
    rd_done_cnt   = 0;
    bi_req_cycles = 0;
    rb_db_rw             = rw;
    rb_db_length         = len;
    rb_db_max_burst_size = mbs;
    rb_db_start          = 1'b1;
    tick;
    rb_db_start = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (!db_rb_idle && n < 200) begin
      tick;
      n++;
    end
    check(tag, db_rb_idle, 1);
  endtask

  task automatic wait_req(input string tag);
    int n;
    n = 0;
    while (!db_bi_req && n < 20) begin
      tick;
      n++;
    end
    check(tag, db_bi_req, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "simulation time limit");
  end

  initial begin
    rst_n = 1'b0;
    rb_db_start = 1'b0;
    rb_db_rw = 1'b0;
    rb_db_length = 8'd0;
    rb_db_max_burst_size = 8'd0;
    bi_db_gnt = 1'b0;
    bi_db_wready = 1'b0;
    bi_db_rdata = 8'd0;
    bi_db_rvalid = 1'b0;
    rd_done_cnt = 0;
    bi_req_cycles = 0;
    for (int i = 0; i < 256; i++) begin
      bank[i] = 8'(i * 7 + 3);
      rmem[i] = 8'd0;
    end

    // Reset state
    #12;
    check("rst_idle", db_rb_idle, 1);
    check("rst_bi_req", db_bi_req, 0);
    check("rst_rb_req", db_rb_req, 0);
    check("rst_wvalid", db_bi_wvalid, 0);
    check("rst_rd_done", db_rb_rd_done, 0);
    check("rst_bi_rw", db_bi_rw, 0);
    check("rst_err", db_err, 0);
    rst_n = 1'b1;
    tick;

    // Write out, length 10, mbs 4, full-rate handshakes
    bi_db_gnt = 1'b1;
    bi_db_wready = 1'b1;
    start_xfer(1'b1, 8'd10, 8'd4);
    check("t1_idle_drop", db_rb_idle, 0);
    wait_idle("t1_idle_return");
    check("t1_nbursts", burst_addr_q.size(), 3);
    for (int b = 0; b < 3; b++) begin
      check("t1_burst_addr", burst_addr_q[b], t1_addr[b]);
      check("t1_burst_size", burst_size_q[b], t1_size[b]);
    end
    check("t1_nbeats", wb_addr_q.size(), 10);
    for (int k = 0; k < 10; k++) begin
      check("t1_beat_addr", wb_addr_q[k], k);
      check("t1_beat_wdata", wb_data_q[k], bank[k]);
    end
    check("t1_no_rd_done", rd_done_cnt, 0);

    // Read in, length 5, mbs 8, rvalid every other cycle
    bi_db_wready = 1'b0;
    start_xfer(1'b0, 8'd5, 8'd8);
    wait_req("t2_req");
    check("t2_size", db_bi_size, 5);
    check("t2_addr", db_bi_addr, 0);
    check("t2_rw", db_bi_rw, 0);
    tick;
    for (int k = 0; k < 5; k++) begin
      bi_db_rdata  = 8'(8'hA0 + k);
      bi_db_rvalid = 1'b1;
      #1;
      check("t2_rb_req", db_rb_req, 1);
      check("t2_rb_addr", db_rb_addr, k);
      check("t2_rb_data", db_rb_data, 8'hA0 + k);
      tick;
      bi_db_rvalid = 1'b0;
      #1;
      check("t2_rb_req_gap", db_rb_req, 0);
      tick;
    end
    check("t2_rd_done", db_rb_rd_done, 1);
    check("t2_idle_in_done", db_rb_idle, 0);
    tick;
    check("t2_rd_done_end", db_rb_rd_done, 0);
    check("t2_idle_return", db_rb_idle, 1);
    check("t2_rd_done_cnt", rd_done_cnt, 1);
    check("t2_nbursts", burst_addr_q.size(), 1);
    for (int k = 0; k < 5; k++) check("t2_bank", rmem[k], 8'hA0 + k);

    // Zero length: SETUP then DONE, no burst
    start_xfer(1'b1, 8'd0, 8'd4);
    check("t3_idle_setup", db_rb_idle, 0);
    tick;
    check("t3_idle_done", db_rb_idle, 0);
    tick;
    check("t3_idle_back", db_rb_idle, 1);
    check("t3_no_bi_req", bi_req_cycles, 0);

    // mbs 0 is treated as 1
    bi_db_wready = 1'b1;
    start_xfer(1'b1, 8'd3, 8'd0);
    wait_idle("t4_idle");
    check("t4_nbursts", burst_addr_q.size(), 3);
    for (int b = 0; b < 3; b++) begin
      check("t4_burst_addr", burst_addr_q[b], b);
      check("t4_burst_size", burst_size_q[b], 1);
    end
    check("t4_nbeats", wb_addr_q.size(), 3);

    // Delayed grant and wready stall on beat 2
    bi_db_gnt = 1'b0;
    bi_db_wready = 1'b0;
    start_xfer(1'b1, 8'd4, 8'd4);
    wait_req("t5_req");
    for (int c = 0; c < 2; c++) begin
      check("t5_req_hold", db_bi_req, 1);
      check("t5_addr_hold", db_bi_addr, 0);
      check("t5_size_hold", db_bi_size, 4);
      tick;
    end
    bi_db_gnt = 1'b1;
    tick;
    bi_db_gnt = 1'b0;
    bi_db_wready = 1'b1;
    #1;
    check("t5_wvalid0", db_bi_wvalid, 1);
    check("t5_addr0", db_rb_addr, 0);
    check("t5_wdata0", db_bi_wdata, bank[0]);
    tick;
    check("t5_addr1", db_rb_addr, 1);
    check("t5_wdata1", db_bi_wdata, bank[1]);
    tick;
    bi_db_wready = 1'b0;
    #1;
    for (int c = 0; c < 3; c++) begin
      check("t5_stall_wvalid", db_bi_wvalid, 1);
      check("t5_stall_addr", db_rb_addr, 2);
      check("t5_stall_wdata", db_bi_wdata, bank[2]);
      tick;
    end
    bi_db_wready = 1'b1;
    #1;
    check("t5_addr2", db_rb_addr, 2);
    tick;
    check("t5_addr3", db_rb_addr, 3);
    check("t5_wdata3", db_bi_wdata, bank[3]);
    tick;
    bi_db_wready = 1'b0;
    wait_idle("t5_idle");
    check("t5_nbeats", wb_addr_q.size(), 4);
    for (int k = 0; k < 4; k++) begin
      check("t5_beat_addr", wb_addr_q[k], k);
      check("t5_beat_wdata", wb_data_q[k], bank[k]);
    end

    // Asynchronous reset mid-WBEAT
    bi_db_gnt = 1'b1;
    start_xfer(1'b1, 8'd4, 8'd4);
    wait_req("t6_req");
    tick;
    check("t6_in_wbeat", db_bi_wvalid, 1);
    rst_n = 1'b0;
    #1;
    check("t6_rst_idle", db_rb_idle, 1);
    check("t6_rst_wvalid", db_bi_wvalid, 0);
    check("t6_rst_rb_req", db_rb_req, 0);
    check("t6_rst_bi_req", db_bi_req, 0);
    check("t6_rst_bi_rw", db_bi_rw, 0);
    check("t6_rst_err", db_err, 0);
    tick;
    rst_n = 1'b1;
    tick;
    check("t6_idle_after", db_rb_idle, 1);

`ifdef DB_TIMEOUT_EN
    // Grant never arrives: abort after 8 cycles in REQ
    bi_db_gnt = 1'b0;
    start_xfer(1'b0, 8'd2, 8'd4);
    wait_req("t7_req");
    n_cyc = 0;
    while (db_bi_req && n_cyc < 50) begin
      tick;
      n_cyc++;
    end
    check("t7_req_cycles", n_cyc, 8);
    check("t7_err", db_err, 1);
    check("t7_no_rd_done", db_rb_rd_done, 0);
    check("t7_idle_in_done", db_rb_idle, 0);
    tick;
    check("t7_idle_back", db_rb_idle, 1);
    check("t7_err_sticky", db_err, 1);
    start_xfer(1'b1, 8'd0, 8'd1);
    check("t7_err_in_setup", db_err, 1);
    tick;
    check("t7_err_cleared", db_err, 0);
    tick;
    check("t7_idle_final", db_rb_idle, 1);
`else
    check("err_tied_low", db_err, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
